// File: rtl/uart_ctl_pkg.sv
// Shared types and constants for the UART control blocks.
package uart_ctl_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE,
    GAP
  } tx_sched_state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int unsigned grant_idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester/UART-side signal bundle of the transmit scheduler.
interface uart_tx_sched_if
  import uart_ctl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  localparam int unsigned IDX_W = grant_idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [UART_DATA_W*NUM_REQ-1:0] req_data;
  logic                           tx_pause;
  logic                           tx_empty;
  logic [NUM_REQ-1:0]             ack;
  logic [IDX_W-1:0]               grant_id;
  logic                           ld_tx_data;
  logic [UART_DATA_W-1:0]         tx_data;
  logic                           tx_enable;
  logic                           busy;

  modport master (
    input  req, req_data, tx_pause, tx_empty,
    output ack, grant_id, ld_tx_data, tx_data, tx_enable, busy
  );

  modport slave (
    output req, req_data, tx_pause, tx_empty,
    input  ack, grant_id, ld_tx_data, tx_data, tx_enable, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module rr_arbiter
  import uart_ctl_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = grant_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  always_comb begin
    int unsigned cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    // Offsets 1..NUM_REQ so the previous winner is considered last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
module uart_tx_sched
  import uart_ctl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic            txclk,
  input  logic            reset,
  uart_tx_sched_if.master bus
);

  localparam int unsigned IDX_W = grant_idx_w(NUM_REQ);
  localparam int unsigned GAP_W = 4;

  tx_sched_state_t        state_q, state_d;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       grant_id_q;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [UART_DATA_W-1:0] tx_data_q;
  logic                   grant_en;
  logic                   gnt_valid;
  logic [IDX_W-1:0]       gnt_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (bus.req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (grant_en) begin
        tx_data_q  <= bus.req_data[UART_DATA_W*gnt_idx +: UART_DATA_W];
        grant_id_q <= gnt_idx;
        ptr_q      <= gnt_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid && !bus.tx_pause && bus.tx_empty) begin
          grant_en = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: state_d = WAIT_START;
      WAIT_START: begin
        if (!bus.tx_empty) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_empty) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        // Counter loaded with GAP_CYCLES-1, so GAP lasts exactly GAP_CYCLES cycles.
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.ack[i] = (state_q == LOAD) && (grant_id_q == IDX_W'(i));
    end
  end

  assign bus.ld_tx_data = (state_q == LOAD);
  assign bus.tx_enable  = (state_q == LOAD) || (state_q == WAIT_START) || (state_q == WAIT_DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant_id   = grant_id_q;
  assign bus.tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: per-cycle vector table plus multi-cycle sequences.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(4)) aif ();
  uart_tx_sched_if #(.NUM_REQ(4)) bif ();

  uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(2)) dut_a (
    .txclk (clk),
    .reset (rst_a),
    .bus   (aif.master)
  );

  uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(0)) dut_b (
    .txclk (clk),
    .reset (rst_b),
    .bus   (bif.master)
  );

  typedef struct {
    logic [3:0]  req;
    logic        pause;
    logic        empty;
    logic        ld;
    logic [3:0]  ack;
    logic [1:0]  gid;
    logic [7:0]  txd;
    logic        busy;
    logic        en;
  } vec_t;

  vec_t vecs [23];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ack_cnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic count_ack();
    for (int i = 0; i < 4; i++) ack_cnt[i] += int'(aif.ack[i]);
  endtask

  // Waits for a load strobe on DUT A, bounded.
  task automatic wait_ld_a(input string name, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(posedge clk); #1;
      count_ack();
      if (aif.ld_tx_data) seen = 1'b1;
    end
    chk({name, " ld seen"}, 32'(seen), 32'd1);
  endtask

  // Checks one granted byte, then plays a short UART frame on tx_empty.
  task automatic serve_a(input int id);
    bit seen;
    logic [7:0] exp_byte;
    exp_byte = 8'(8'h11 * (id + 1));
    wait_ld_a($sformatf("rr%0d", id), seen);
    if (seen) begin
      chk($sformatf("rr%0d ack", id), 32'(aif.ack), 32'(1 << id));
      chk($sformatf("rr%0d gid", id), 32'(aif.grant_id), 32'(id));
      chk($sformatf("rr%0d txd", id), 32'(aif.tx_data), 32'(exp_byte));
    end
    aif.tx_empty = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      count_ack();
    end
    aif.tx_empty = 1'b1;
  endtask

  initial begin
    bit seen;
    //           req      pse   emp   ld    ack      gid    txd    busy  en
    vecs[0]  = '{4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 2'd0, 8'hA5, 1'b1, 1'b1};
    vecs[1]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 8'hA5, 1'b1, 1'b1};
    vecs[2]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 8'hA5, 1'b1, 1'b1};
    vecs[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 8'hA5, 1'b1, 1'b1};
    vecs[4]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 8'hA5, 1'b1, 1'b1};
    vecs[5]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 8'hA5, 1'b1, 1'b0};
    vecs[6]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 8'hA5, 1'b1, 1'b0};
    vecs[7]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 8'hA5, 1'b0, 1'b0};
    vecs[8]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 8'hA5, 1'b0, 1'b0};
    vecs[9]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 8'hA5, 1'b0, 1'b0};
    vecs[10] = '{4'b0010, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h3C, 1'b1, 1'b1};
    vecs[11] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 8'h3C, 1'b1, 1'b1};
    vecs[12] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 8'h3C, 1'b1, 1'b1};
    vecs[13] = '{4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1, 8'h3C, 1'b1, 1'b0};
    vecs[14] = '{4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1, 8'h3C, 1'b1, 1'b0};
    vecs[15] = '{4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1, 8'h3C, 1'b0, 1'b0};
    vecs[16] = '{4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1, 8'h3C, 1'b0, 1'b0};
    vecs[17] = '{4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, 2'd2, 8'h77, 1'b1, 1'b1};
    vecs[18] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 8'h77, 1'b1, 1'b1};
    vecs[19] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 8'h77, 1'b1, 1'b1};
    vecs[20] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd2, 8'h77, 1'b1, 1'b0};
    vecs[21] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd2, 8'h77, 1'b1, 1'b0};
    vecs[22] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd2, 8'h77, 1'b0, 1'b0};

    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    aif.req = '0; aif.req_data = 32'h0077_3CA5; aif.tx_pause = 1'b0; aif.tx_empty = 1'b1;
    bif.req = '0; bif.req_data = 32'h0000_BB11; bif.tx_pause = 1'b0; bif.tx_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(aif.busy), 32'd0);
    chk("reset ld",   32'(aif.ld_tx_data), 32'd0);
    chk("reset ack",  32'(aif.ack), 32'd0);
    chk("reset gid",  32'(aif.grant_id), 32'd0);
    chk("reset txd",  32'(aif.tx_data), 32'd0);
    chk("reset en",   32'(aif.tx_enable), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 23; i++) begin
      aif.req      = vecs[i].req;
      aif.tx_pause = vecs[i].pause;
      aif.tx_empty = vecs[i].empty;
      @(posedge clk); #1;
      chk($sformatf("v%0d ld", i),   32'(aif.ld_tx_data), 32'(vecs[i].ld));
      chk($sformatf("v%0d ack", i),  32'(aif.ack),        32'(vecs[i].ack));
      chk($sformatf("v%0d gid", i),  32'(aif.grant_id),   32'(vecs[i].gid));
      chk($sformatf("v%0d txd", i),  32'(aif.tx_data),    32'(vecs[i].txd));
      chk($sformatf("v%0d busy", i), 32'(aif.busy),       32'(vecs[i].busy));
      chk($sformatf("v%0d en", i),   32'(aif.tx_enable),  32'(vecs[i].en));
    end

    // Round robin with all four requesters held: 0,1,2,3,0.
    #2 rst_a = 1'b1;
    #2 rst_a = 1'b0;
    aif.req_data = 32'h4433_2211;
    aif.tx_empty = 1'b1;
    aif.req      = 4'b1111;
    serve_a(0);
    serve_a(1);
    serve_a(2);
    serve_a(3);
    serve_a(0);
    aif.req = 4'b0000;
    chk("rr ack count 0", 32'(ack_cnt[0]), 32'd2);
    chk("rr ack count 1", 32'(ack_cnt[1]), 32'd1);
    chk("rr ack count 2", 32'(ack_cnt[2]), 32'd1);
    chk("rr ack count 3", 32'(ack_cnt[3]), 32'd1);

    // Reset pulsed during WAIT_START.
    #2 rst_a = 1'b1;
    #2 rst_a = 1'b0;
    aif.req = 4'b0010;
    wait_ld_a("abort", seen);
    aif.req = 4'b0000;
    @(posedge clk); #1;
    chk("abort ws busy", 32'(aif.busy), 32'd1);
    chk("abort ws en",   32'(aif.tx_enable), 32'd1);
    #2 rst_a = 1'b1;
    #1;
    chk("abort busy", 32'(aif.busy), 32'd0);
    chk("abort en",   32'(aif.tx_enable), 32'd0);
    chk("abort ack",  32'(aif.ack), 32'd0);
    chk("abort gid",  32'(aif.grant_id), 32'd0);
    chk("abort txd",  32'(aif.tx_data), 32'd0);
    #1 rst_a = 1'b0;
    aif.req = 4'b1001;
    wait_ld_a("post reset", seen);
    chk("post reset gid", 32'(aif.grant_id), 32'd0);
    chk("post reset ack", 32'(aif.ack), 32'b0001);
    chk("post reset txd", 32'(aif.tx_data), 32'h11);
    aif.req = 4'b0000;

    // GAP_CYCLES = 0: next grant one cycle after tx_empty rises.
    bif.req = 4'b0001;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(posedge clk); #1;
      if (bif.ld_tx_data) seen = 1'b1;
    end
    chk("nogap first ld seen", 32'(seen), 32'd1);
    chk("nogap first txd", 32'(bif.tx_data), 32'h11);
    bif.req = 4'b0010;
    bif.tx_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("nogap wd busy", 32'(bif.busy), 32'd1);
    bif.tx_empty = 1'b1;
    @(posedge clk); #1;
    chk("nogap idle busy", 32'(bif.busy), 32'd0);
    chk("nogap idle ld",   32'(bif.ld_tx_data), 32'd0);
    @(posedge clk); #1;
    chk("nogap ld",  32'(bif.ld_tx_data), 32'd1);
    chk("nogap ack", 32'(bif.ack), 32'b0010);
    chk("nogap gid", 32'(bif.grant_id), 32'd1);
    chk("nogap txd", 32'(bif.tx_data), 32'hBB);
    bif.req = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single UART transmitter between `NUM_REQ` byte producers. It picks one pending requester, loads its byte into the UART through the `ld_tx_data`/`tx_data`/`tx_enable` load port, and tracks the UART's `tx_empty` flag until the byte has left. It then enforces an inter-byte gap before granting again. It sits directly in front of the UART in the same clock domain.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `GAP_CYCLES`, default 2: idle cycles inserted after each byte completes, range 0..15.
- `txclk` in 1: transmit clock; every register in the block uses it.
- `reset` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: per-requester byte-pending flags.
- `req_data` in 8*NUM_REQ: flattened bytes; requester i drives `[8*i+7:8*i]`.
- `tx_pause` in 1: when high, blocks new grants.
- `tx_empty` in 1: from the UART; high means the UART holds no byte.
- `ack` out NUM_REQ: one-hot, one-cycle pulse; the byte has been taken.
- `grant_id` out clog2(NUM_REQ): index of the last-granted requester.
- `ld_tx_data` out 1: one-cycle load strobe to the UART.
- `tx_data` out 8: byte presented to the UART.
- `tx_enable` out 1: UART shift enable.
- `busy` out 1: high in every state except IDLE.

## Operation
- The FSM has five states: IDLE, LOAD, WAIT_START, WAIT_DONE, GAP.
- **IDLE**
  - Grants only when `req != 0`, `tx_pause == 0` and `tx_empty == 1`.
  - Winner: first set bit searching from `ptr+1` modulo NUM_REQ.
  - On a grant: latch `tx_data <= req_data[winner]`, `grant_id <= winner`, `ptr <= winner`, go to LOAD.
- **LOAD** lasts exactly one cycle.
  - `ld_tx_data = 1` and `ack[grant_id] = 1`.
  - Go to WAIT_START.
- **WAIT_START**: wait for `tx_empty == 0` (the UART has latched the byte), then go to WAIT_DONE.
- **WAIT_DONE**: wait for `tx_empty == 1`.
  - If `GAP_CYCLES == 0`, go to IDLE.
  - Otherwise load `gap_cnt = GAP_CYCLES-1` and go to GAP.
- **GAP**: decrement `gap_cnt`; go to IDLE when it reaches 0.
- `tx_enable = 1` in LOAD, WAIT_START and WAIT_DONE; 0 in IDLE and GAP.
- All outputs are registered, or decoded from the state register only. There is no combinational path from `req` to any output.
- Requester contract:
  - Hold `req` and `req_data` stable until its `ack` pulse.
  - May present the next byte in the cycle after `ack`.
  - A `req` dropped before the grant is simply not served.
- `tx_pause` only gates the IDLE grant decision. A byte already in flight completes normally.
- `tx_data` holds the last byte until the next grant.

## Timing
- Reset values:
  - State IDLE, `ptr = NUM_REQ-1` (so requester 0 wins first), `gap_cnt = 0`.
  - `ack = 0`, `grant_id = 0`, `ld_tx_data = 0`, `tx_data = 8'h00`, `tx_enable = 0`, `busy = 0`.
- Reset asserted mid-operation: every output clears asynchronously. No `ack` is issued for an aborted load. The UART shares the same `reset`.
- Grant latency: `req` sampled high in IDLE at edge T gives `ld_tx_data`/`ack` high for the cycle after T.
- Minimum spacing between consecutive `ld_tx_data` pulses: 4 + GAP_CYCLES + UART frame time.
- Simultaneous requests are resolved by round-robin only; there are no fixed priorities.
- A requester that re-requests immediately after `ack` is served only after every other pending requester.
- Pointer wrap: with `ptr = NUM_REQ-1` the search starts at 0.
- `tx_empty` already low in IDLE (UART occupied by another path): no grant, and the FSM stays in IDLE.

## Structure
- Shared package `uart_ctl_pkg`:
  - State enum `tx_sched_state_t` (IDLE, LOAD, WAIT_START, WAIT_DONE, GAP).
  - Constant `UART_DATA_W = 8`.
  - Function for the grant-index width.
- One sub-module: `rr_arbiter`, purely combinational.
  - Inputs: `req`, `ptr`.
  - Outputs: `gnt_valid`, `gnt_idx`.
  - The FSM, pointer, gap counter and output registers stay in `uart_tx_sched`.

## Test plan
- Reset then `req = 4'b0001`, `req_data[7:0] = 8'hA5`:
  - `ld_tx_data` and `ack = 4'b0001` pulse one cycle after the request.
  - `tx_data = 8'hA5`.
  - `busy` stays high until `tx_empty` returns high plus 2 gap cycles.
- `req = 4'b1111` held continuously: grant order is 0, 1, 2, 3, 0, with each `ack` exactly once per byte.
- `tx_pause = 1` asserted during WAIT_DONE with `req = 4'b0100`:
  - The current byte finishes.
  - No `ld_tx_data` occurs while paused.
  - Requester 2 is granted in the cycle after `tx_pause` falls.
- `GAP_CYCLES = 0`: the FSM goes from WAIT_DONE directly to IDLE, and the next grant follows the `tx_empty` rise by one cycle.
- `reset` pulsed while in WAIT_START: outputs clear immediately, no `ack`, and requester 0 has first priority afterwards.
- `tx_empty` held low at IDLE with `req = 4'b0010`: no grant and no `ld_tx_data` until `tx_empty` goes high.
